// File: rtl/bus_interrupt_controller.sv
// Bus-mapped interrupt controller: latches N_CH peripheral requests into PENDING and raises one processor IRQ.
// Optional OVERRUN register at BASE_ADDR+3 is built when INTC_OVERRUN_EN is defined.
module bus_interrupt_controller #(
  parameter int          N_CH       = 4,
  parameter logic [7:0]  BASE_ADDR  = 8'h90,
  parameter logic [7:0]  RESET_MASK = 8'hFF
) (
  input  logic            CLK,
  input  logic            RESET,
  inout  wire  [7:0]      BUS_DATA,
  input  logic [7:0]      BUS_ADDR,
  input  logic            BUS_WE,
  input  logic [N_CH-1:0] CH_RAISE,
  output logic [N_CH-1:0] CH_ACK,
  output logic            IRQ_RAISE,
  input  logic            IRQ_ACK
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

  state_t          state_r, state_next_s;
  logic            in_service_r, in_service_next_s;
  logic            irq_r;
  logic [N_CH-1:0] enable_r, pending_r, guard_r, ack_r;
  logic [N_CH-1:0] wdata_s, cap_s, masked_s, pending_next_s, enable_next_s;
  logic [7:0]      offset_s, vector_s, rd_data_next_s, rd_data_r;
  logic            hit_s, wr_en_s, wr_pend_s, any_s, rd_valid_r;
  logic            unused_s;
`ifdef INTC_OVERRUN_EN
  logic [N_CH-1:0] overrun_r, overrun_next_s;
  logic            wr_ovr_s;
`endif

  function automatic logic [2:0] lowest_index(input logic [N_CH-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign offset_s  = BUS_ADDR - BASE_ADDR;
  assign wdata_s   = BUS_DATA[N_CH-1:0];
  // Upper data bits are meaningless when N_CH < 8
  assign unused_s  = ^BUS_DATA;
  assign wr_en_s   = BUS_WE && (offset_s == 8'd0);
  assign wr_pend_s = BUS_WE && (offset_s == 8'd1);
`ifdef INTC_OVERRUN_EN
  assign wr_ovr_s  = BUS_WE && (offset_s == 8'd3);
  assign hit_s     = (offset_s <= 8'd3);
`else
  assign hit_s     = (offset_s <= 8'd2);
`endif

  // Guard blocks re-capture until the peripheral drops its request
  assign cap_s    = CH_RAISE & ~guard_r;
  assign masked_s = pending_r & enable_r;
  assign any_s    = |masked_s;
  assign vector_s = any_s ? {1'b1, 4'b0000, lowest_index(masked_s)} : 8'h00;

  // Next register values: capture wins over write-1-to-clear
  always_comb begin
    pending_next_s = pending_r | cap_s;
    enable_next_s  = enable_r;
    if (wr_pend_s) begin
      pending_next_s = (pending_r & ~wdata_s) | cap_s;
    end else begin
      pending_next_s = pending_r | cap_s;
    end
    if (wr_en_s) begin
      enable_next_s = wdata_s;
    end else begin
      enable_next_s = enable_r;
    end
  end

`ifdef INTC_OVERRUN_EN
  // Overrun flags: a fresh capture onto an already pending bit
  always_comb begin
    overrun_next_s = overrun_r | (cap_s & pending_r);
    if (wr_ovr_s) begin
      overrun_next_s = (overrun_r & ~wdata_s) | (cap_s & pending_r);
    end else begin
      overrun_next_s = overrun_r | (cap_s & pending_r);
    end
  end
`endif

  // Read data mux for the registered read path
  always_comb begin
    rd_data_next_s = 8'h00;
    case (offset_s)
      8'd0:    rd_data_next_s = 8'(enable_r);
      8'd1:    rd_data_next_s = 8'(pending_r);
      8'd2:    rd_data_next_s = vector_s;
`ifdef INTC_OVERRUN_EN
      8'd3:    rd_data_next_s = 8'(overrun_r);
`endif
      default: rd_data_next_s = 8'h00;
    endcase
  end

  // Processor-side request FSM: next state and in-service flag
  always_comb begin
    state_next_s      = state_r;
    in_service_next_s = in_service_r;
    case (state_r)
      IDLE: begin
        if (any_s && !in_service_r) state_next_s = REQ;
        else                        state_next_s = IDLE;
      end
      REQ: begin
        if (IRQ_ACK) begin
          state_next_s      = SERVICE;
          in_service_next_s = 1'b1;
        end else if (!any_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = REQ;
        end
      end
      SERVICE: begin
        if (wr_pend_s) begin
          state_next_s      = IDLE;
          in_service_next_s = 1'b0;
        end else begin
          state_next_s = SERVICE;
        end
      end
      default: begin
        state_next_s      = IDLE;
        in_service_next_s = 1'b0;
      end
    endcase
  end

  // FSM state register; IRQ_RAISE follows the registered REQ state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r      <= IDLE;
      in_service_r <= 1'b0;
      irq_r        <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      in_service_r <= in_service_next_s;
      irq_r        <= (state_next_s == REQ);
    end
  end

  // Channel capture, software registers and registered bus read
  always_ff @(posedge CLK) begin
    if (RESET) begin
      enable_r   <= RESET_MASK[N_CH-1:0];
      pending_r  <= '0;
      guard_r    <= '0;
      ack_r      <= '0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= 8'h00;
`ifdef INTC_OVERRUN_EN
      overrun_r  <= '0;
`endif
    end else begin
      enable_r   <= enable_next_s;
      pending_r  <= pending_next_s;
      guard_r    <= CH_RAISE;
      ack_r      <= cap_s;
      rd_valid_r <= hit_s && !BUS_WE;
      rd_data_r  <= rd_data_next_s;
`ifdef INTC_OVERRUN_EN
      overrun_r  <= overrun_next_s;
`endif
    end
  end

  assign CH_ACK    = ack_r;
  assign IRQ_RAISE = irq_r;
  assign BUS_DATA  = rd_valid_r ? rd_data_r : 8'hzz;

endmodule

// File: doc/bus_interrupt_controller.md
Name: bus_interrupt_controller

Overview:
- Parametrised interrupt controller between N_CH peripheral interrupt sources and one processor interrupt line (BUS_INTERRUPTS_RAISE/ACK bit).
- Replaces direct wiring of each peripheral's raise/ack pair to the processor.
- Latches events into a pending register and acks peripherals at once, so no event is lost.
- Software sees memory-mapped enable, pending and priority-vector registers on the shared 8-bit bus.

Parameters:
- N_CH, 4, number of peripheral channels (1..8); channel 0 has highest priority.
- BASE_ADDR, 8'h90, bus base address; registers at BASE_ADDR+0..+3.
- RESET_MASK, 8'hFF, reset value of ENABLE; bits at N_CH and above are ignored.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  synchronous active-high reset.
- BUS_DATA  inout  8  shared data bus; driven only during a read of this block.
- BUS_ADDR  input  8  bus address.
- BUS_WE  input  1  bus write enable.
- CH_RAISE  input  N_CH  peripheral interrupt requests, level, held until acked.
- CH_ACK  output  N_CH  one-cycle ack pulse per channel.
- IRQ_RAISE  output  1  interrupt request to processor.
- IRQ_ACK  input  1  processor ack, one-cycle pulse.

Behaviour:
- Clocking and reset:
  - One clock (CLK); reset is synchronous and active-high (RESET).
  - Reset values: ENABLE=RESET_MASK, PENDING=0, in_service=0, guard=0, CH_ACK=0, IRQ_RAISE=0, BUS_DATA tri-stated.
- Register map:
  - +0 ENABLE, R/W.
  - +1 PENDING: read returns state; write is write-1-to-clear.
  - +2 VECTOR, read-only: bit7 = any (PENDING&ENABLE); bits2:0 = lowest set index; reads 0x00 if none.
  - Unimplemented bits read 0. Writes to +2 are ignored.
- Bus timing:
  - Write takes effect at the clock edge where BUS_WE=1 and the address matches.
  - Read data is registered from the address in cycle t. BUS_DATA is driven during cycle t+1 only, if t had BUS_WE=0 and an address match. Otherwise BUS_DATA is Z.
- Channel capture, per channel i:
  - If CH_RAISE[i]=1 and guard[i]=0: PENDING[i] is set, CH_ACK[i]=1 for exactly the next cycle, guard[i] is set.
  - guard[i] clears when CH_RAISE[i] is sampled 0. This prevents double capture while the peripheral drops its request.
  - Disabled channels still latch PENDING. ENABLE only gates IRQ_RAISE.
  - Capture and W1C of the same bit in the same cycle: the set wins.
- Processor-side FSM (IDLE, REQ, SERVICE):
  - IDLE -> REQ when (PENDING&ENABLE)!=0 and in_service=0. IRQ_RAISE=1 from the next cycle.
  - REQ -> SERVICE on IRQ_ACK: IRQ_RAISE=0 next cycle, in_service=1.
  - REQ -> IDLE if (PENDING&ENABLE) becomes 0 before ack (e.g. mask written). IRQ_RAISE falls next cycle.
  - SERVICE -> IDLE on any write to +1: in_service=0. If events remain, REQ is re-entered the following cycle.
  - IRQ_ACK outside REQ is ignored.
- Reset mid-operation: all state returns to reset values on the next edge, including pending events and any ACK pulse in flight.
- IRQ_RAISE is a register output with no combinational path from bus or CH_RAISE.

Optional Feature:
- Macro INTC_OVERRUN_EN.
- With it defined:
  - Register +3 OVERRUN (R, write-1-to-clear) exists.
  - OVERRUN[i] sets when a new capture occurs on channel i while PENDING[i] is already 1.
  - OVERRUN resets to 0.
  - Set wins over a simultaneous clear.
- Without it: +3 is not decoded and BUS_DATA stays Z on reads of +3.

Test Plan:
- Reset, then read +0, +1, +2 -> 0x0F, 0x00, 0x00; IRQ_RAISE=0; BUS_DATA is Z outside read cycles.
- Hold CH_RAISE[2]=1 for 5 cycles -> exactly one CH_ACK[2] pulse, PENDING=0x04, IRQ_RAISE=1 two cycles after first sample, VECTOR=0x82.
- CH_RAISE[3] and CH_RAISE[1] asserted together -> PENDING=0x0A, VECTOR=0x81. IRQ_ACK pulse drops IRQ_RAISE next cycle. Write 0x02 to +1 -> PENDING=0x08, IRQ_RAISE reasserts, VECTOR=0x83.
- Write ENABLE=0x00, then raise channel 0 -> PENDING=0x01, IRQ_RAISE stays 0. Write ENABLE=0x01 -> IRQ_RAISE=1 next cycle.
- Capture on channel 1 in the same cycle as a W1C 0x02 write -> PENDING[1] stays 1.
- With INTC_OVERRUN_EN: two captures on channel 0 with no clear between -> +3 reads 0x01. Write 0x01 to +3 -> reads 0x00. Without the macro: read of +3 leaves BUS_DATA Z.
